// File: rtl/sample_stream_serializer.sv
// -----------------------------------------------------------------------------
// sample_stream_serializer
//
// Width-converting stream source. Accepts WORD_WIDTH-bit words together with a
// byte count, buffers them in a small word FIFO and emits the valid bytes
// LSB-first on a BYTE_WIDTH-bit stream with a last-byte marker. The output
// side connects directly to a downstream consumer's stream_in_* ports.
//
// Parameters
//   WORD_WIDTH   input word width; must equal BYTE_WIDTH * 8
//   BYTE_WIDTH   output byte width
//   FIFO_DEPTH   word FIFO entries; power of two, >= 2
//   COUNT_WIDTH  width of the byte/word statistics counters (wrap, no saturate)
//
// Ports
//   clk, reset        single rising-edge clock, synchronous active-high reset
//   word_in_valid     upstream word valid
//   word_in_ready     FIFO can take a word (0 for the cycle after reset is seen)
//   word_in_data      word payload, byte 0 = bits [BYTE_WIDTH-1:0]
//   word_in_nbytes    valid bytes in the word, 1..8; 0 and >8 mean 8
//   stream_out_valid  byte valid
//   stream_out_ready  consumer ready
//   stream_out_data   current byte (0 while idle)
//   stream_out_last   high with the final byte of each word
//   fifo_level        words currently buffered
//   byte_count        output byte handshakes since reset
//   word_count        output handshakes carrying last since reset
//   state_dbg         serializer state (0 = IDLE, 1 = SHIFT)
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. A source never withdraws valid or
// changes data/last while waiting for ready. Ready never depends on valid.
// -----------------------------------------------------------------------------
module sample_stream_serializer #(
  parameter int WORD_WIDTH  = 64,
  parameter int BYTE_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          word_in_valid,
  output logic                          word_in_ready,
  input  logic [WORD_WIDTH-1:0]         word_in_data,
  input  logic [3:0]                    word_in_nbytes,
  output logic                          stream_out_valid,
  input  logic                          stream_out_ready,
  output logic [BYTE_WIDTH-1:0]         stream_out_data,
  output logic                          stream_out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [COUNT_WIDTH-1:0]        byte_count,
  output logic [COUNT_WIDTH-1:0]        word_count,
  output logic                          state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int NB    = WORD_WIDTH / BYTE_WIDTH;

  localparam logic [3:0]       NB_MAX  = 4'(NB);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Reset delay: the input side stays closed for one cycle after reset is seen
  // ---------------------------------------------------------------------------
  logic reset_q;

  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic [WORD_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [3:0]            mem_nb   [FIFO_DEPTH];
  logic                  fifo_empty;
  logic                  wr_en;
  logic                  pop;
  logic [3:0]            in_nb_clamped;

  assign fifo_empty    = (level_q == '0);
  assign word_in_ready = !reset_q && (level_q < DEPTH_L);
  assign wr_en         = word_in_valid && word_in_ready;

  // Byte count is normalised on the way in so the serializer only ever sees
  // 1..NB: 0 means a full word and anything above NB is clamped.
  assign in_nb_clamped = ((word_in_nbytes == 4'd0) || (word_in_nbytes > NB_MAX))
                         ? NB_MAX : word_in_nbytes;

  // Storage has no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr_q] <= word_in_data;
      mem_nb[wr_ptr_q]   <= in_nb_clamped;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({wr_en, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // IDLE only starts a word one cycle after the FIFO became non-empty, so a
  // word written into an empty FIFO is never read in the cycle it lands in
  // storage. While shifting, the live level is used so words chain without a
  // bubble.
  logic avail_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      avail_q <= 1'b0;
    end else begin
      avail_q <= !fifo_empty;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM
  // ---------------------------------------------------------------------------
  state_e                state_q;
  state_e                state_d;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [3:0]            remain_q;
  logic                  idle_take;
  logic                  remain_last;
  logic                  advance;

  assign idle_take   = avail_q && !fifo_empty;
  assign remain_last = (remain_q == 4'd1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (idle_take) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (stream_out_ready && remain_last && fifo_empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / control logic
  always_comb begin
    pop              = 1'b0;
    advance          = 1'b0;
    stream_out_valid = 1'b0;
    stream_out_last  = 1'b0;
    stream_out_data  = '0;
    unique case (state_q)
      ST_IDLE: begin
        pop = idle_take;
      end
      ST_SHIFT: begin
        stream_out_valid = 1'b1;
        stream_out_last  = remain_last;
        stream_out_data  = shift_q[BYTE_WIDTH-1:0];
        if (stream_out_ready) begin
          // Final byte accepted: chain straight into the next word if one
          // is buffered, otherwise the next-state logic returns to IDLE.
          pop     = remain_last && !fifo_empty;
          advance = !remain_last;
        end
      end
      default: begin
        pop = 1'b0;
      end
    endcase
  end

  // Shift register and remaining-byte counter
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q  <= '0;
      remain_q <= '0;
    end else if (pop) begin
      shift_q  <= mem_data[rd_ptr_q];
      remain_q <= mem_nb[rd_ptr_q];
    end else if (advance) begin
      shift_q  <= shift_q >> BYTE_WIDTH;
      remain_q <= remain_q - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics counters (wrap modulo 2^COUNT_WIDTH)
  // ---------------------------------------------------------------------------
  logic [COUNT_WIDTH-1:0] byte_cnt_q;
  logic [COUNT_WIDTH-1:0] word_cnt_q;
  logic                   out_hs;

  assign out_hs = stream_out_valid && stream_out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
    end else if (out_hs) begin
      byte_cnt_q <= byte_cnt_q + COUNT_WIDTH'(1);
      if (stream_out_last) begin
        word_cnt_q <= word_cnt_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign fifo_level = level_q;
  assign byte_count = byte_cnt_q;
  assign word_count = word_cnt_q;
  assign state_dbg  = state_q;

endmodule
